// File: rtl/echo_delay_line.sv
// Echo stage: adds a delayed, attenuated copy of the sample stream to itself (feed-forward or
// feedback). Define ECHO_SATURATE_EN to clamp the sum on overflow instead of wrapping.
module echo_delay_line #(
   parameter int unsigned RESOLUTION = 32,
   parameter int unsigned MAX_DEPTH  = 1024,
   localparam int unsigned AW        = $clog2(MAX_DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   input  logic                  i_feedback,
   input  logic [AW-1:0]         i_delay,
   input  logic [2:0]            i_decay,
   input  logic                  i_in_valid,
   input  logic [RESOLUTION-1:0] i_data_in,
   output logic                  o_out_valid,
   output logic [RESOLUTION-1:0] o_data_out
);

   localparam logic [RESOLUTION-1:0] SatMax = {1'b0, {(RESOLUTION-1){1'b1}}};
   localparam logic [RESOLUTION-1:0] SatMin = {1'b1, {(RESOLUTION-1){1'b0}}};

   logic signed [RESOLUTION-1:0] r_buf [MAX_DEPTH];
   logic [AW-1:0]                r_wr_ptr;
   logic [AW-1:0]                r_fill;
   logic [AW-1:0]                r_delay_q;
   logic                         r_out_valid;
   logic [RESOLUTION-1:0]        r_data_out;

   logic [AW-1:0]                w_rd_addr;
   logic                         w_delay_same;
   logic                         w_tap_valid;
   logic signed [RESOLUTION-1:0] w_tap_raw;
   logic signed [RESOLUTION-1:0] w_echo;
   logic [3:0]                   w_shamt;
   logic [RESOLUTION:0]          w_sum;
   logic [RESOLUTION-1:0]        w_sum_res;
   logic [RESOLUTION-1:0]        w_wr_data;
   logic [AW-1:0]                w_fill_base;
   logic [AW-1:0]                w_fill_next;

   assign w_rd_addr    = r_wr_ptr - r_delay_q;
   assign w_tap_raw    = r_buf[w_rd_addr];
   assign w_delay_same = (i_delay == r_delay_q);
   // A delay change discards history: the tap stays gated until fresh samples cover the delay.
   assign w_tap_valid  = w_delay_same && (r_delay_q != '0) && (r_fill >= r_delay_q);
   assign w_shamt      = {1'b0, i_decay} + 4'd1;

   always_comb begin
      w_echo = '0;
      if (w_tap_valid) begin
         w_echo = w_tap_raw >>> w_shamt;
      end
   end

   assign w_sum = {i_data_in[RESOLUTION-1], i_data_in} + {w_echo[RESOLUTION-1], w_echo};

`ifdef ECHO_SATURATE_EN
   always_comb begin
      w_sum_res = w_sum[RESOLUTION-1:0];
      if (w_sum[RESOLUTION] != w_sum[RESOLUTION-1]) begin
         w_sum_res = w_sum[RESOLUTION] ? SatMin : SatMax;
      end
   end
`else
   logic w_unused_sat;
   assign w_unused_sat = ^{SatMax, SatMin, w_sum[RESOLUTION]};
   assign w_sum_res    = w_sum[RESOLUTION-1:0];
`endif

   assign w_wr_data   = (i_feedback && i_enable) ? w_sum_res : i_data_in;
   assign w_fill_base = w_delay_same ? r_fill : '0;
   assign w_fill_next = (w_fill_base == '1) ? w_fill_base : w_fill_base + AW'(1);

   // Buffer contents are never reset so the array maps onto RAM.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && i_in_valid) begin
         r_buf[r_wr_ptr] <= w_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr    <= '0;
         r_fill      <= '0;
         r_delay_q   <= '0;
         r_out_valid <= 1'b0;
         r_data_out  <= '0;
      end else begin
         r_out_valid <= i_in_valid;
         if (i_in_valid) begin
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_fill     <= w_fill_next;
            r_delay_q  <= i_delay;
            r_data_out <= i_enable ? w_sum_res : i_data_in;
         end
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_data_out  = r_data_out;

endmodule

// File: doc/echo_delay_line.md
# echo_delay_line

Parametrised echo stage for the audio path: adds a delayed, attenuated copy of the signed sample stream to itself, with a run-time programmable delay held in a circular buffer. Sits between the sample source and the output formatter, one sample per `in_valid` strobe. Supports feed-forward (single echo) and feedback (repeating, decaying echo) modes.

## Interface

**Parameters**
- `RESOLUTION`, 32: sample width, two's-complement signed.
- `MAX_DEPTH`, 1024: buffer entries. Must be a power of two, at least 4. `AW = $clog2(MAX_DEPTH)`.

**Ports**
- `clk`, in, 1: sole clock; all logic is rising-edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `enable`, in, 1: 1 = effect applied; 0 = bypass.
- `feedback`, in, 1: 0 = feed-forward (buffer stores dry input); 1 = feedback (buffer stores output).
- `delay`, in, AW: echo delay in samples. Legal range 1..MAX_DEPTH-1; 0 means no echo.
- `decay`, in, 3: attenuation. The echo tap is arithmetic-shifted right by `decay+1` (gain 1/2 .. 1/256).
- `in_valid`, in, 1: `data_in` carries a new sample this cycle.
- `data_in`, in, RESOLUTION: signed input sample.
- `out_valid`, out, 1: one-cycle pulse; `data_out` is updated this cycle.
- `data_out`, out, RESOLUTION: signed output sample; holds its value between pulses.

## Operation

**Storage and pointers**
- Circular buffer `buf[MAX_DEPTH]`, intended for inferred RAM. Contents are not reset.
- Write pointer `wr_ptr` (AW bits) wraps from MAX_DEPTH-1 to 0.
- Tap address: `rd_addr = wr_ptr - delay_q`, modulo MAX_DEPTH.

**Delay/fill tracking**
- `delay_q` samples `delay` on each accepted sample.
- `fill` counter counts accepted samples and saturates at MAX_DEPTH-1.
- The tap is valid only when `fill >= delay_q` and `delay_q != 0`. Otherwise the tap is forced to 0, so stale RAM never reaches the output.
- If `delay` differs from `delay_q` on an accepted sample, `fill` is cleared to 0 on that sample. New echoes therefore appear only after `delay` fresh samples.

**Per accepted sample** (`in_valid`=1)
- `echo = valid_tap ? (buf[rd_addr] >>> (decay+1)) : 0`.
- `sum = data_in + echo`, computed at RESOLUTION+1 bits, then resolved to RESOLUTION bits (see Configuration).
- `enable`=1: `data_out <= sum`.
- `enable`=0: `data_out <= data_in`. The buffer is still written and pointers still advance, so history stays continuous when the effect is re-enabled.
- Write data: `feedback`=0 or `enable`=0 writes `data_in`; `feedback`=1 and `enable`=1 writes the resolved `sum`.
- After the write, `wr_ptr` increments and `fill` increments (saturating).

**Non-sample cycles**
- `in_valid`=0: no state change; `out_valid`=0.

**Control sampling**
- `enable`, `feedback` and `decay` are sampled only on cycles with `in_valid`=1.

## Timing

- Latency: `data_out` and `out_valid` are registered one cycle after the `in_valid` cycle. Throughput is one sample per clock; back-to-back `in_valid` is legal.
- Read-during-write: the tap read and the buffer write in the same cycle use different addresses whenever `delay_q >= 1`. With `delay_q = 0` the tap is forced to 0, so there is no read/write collision.
- Reset (`rst_n`=0 at an edge): `data_out`=0, `out_valid`=0, `wr_ptr`=0, `fill`=0, `delay_q`=0. Reset wins over a simultaneous `in_valid`.
- Reset mid-stream: all echo history is discarded via `fill`. The first post-reset output equals the dry input.
- Delay change with `delay`=MAX_DEPTH-1: the oldest entry is one full wrap back. This is legal once `fill` saturates.

## Configuration

- `ECHO_SATURATE_EN` defined: the RESOLUTION+1-bit `sum` clamps to the most positive value 2^(R-1)-1 or the most negative value -2^(R-1) on overflow. This also bounds the feedback loop.
- `ECHO_SATURATE_EN` undefined: `sum` is truncated to the low RESOLUTION bits (two's-complement wrap). Smaller logic; overflow wraps audibly.

## Test plan

- **Reset/bypass:** reset, `enable`=0, send samples 100, -7, 5 → `out_valid` pulses 1 cycle later each, `data_out` = 100, -7, 5. After reset, `data_out`=0.
- **Feed-forward echo:** `enable`=1, `feedback`=0, `delay`=4, `decay`=0. Send an impulse 1000 then zeros → outputs 1000, 0, 0, 0, 500, then 0 forever.
- **Feedback echo:** same setup with `feedback`=1 → outputs 1000 at sample 0, 500 at sample 4, 250 at sample 8, 125 at sample 12, 62 at sample 16 (arithmetic shift, negative inputs round toward -inf).
- **Fill/delay change:** stream constant 64 with `delay`=8; change `delay` to 3 mid-stream → the next 3 outputs equal 64 (tap gated by `fill`), then 64 + 32 = 96.
- **Overflow:** R=16, `feedback`=0, `delay`=1, `decay`=0, inputs 30000, 30000 → second output is 32767 with `ECHO_SATURATE_EN`; -20536 (45000 wrapped) without it.
- **Wrap/reset mid-op:** MAX_DEPTH=8, `delay`=7. Run 20 samples crossing the pointer wrap and check each output against a reference model. Assert `rst_n` for one cycle mid-stream → next sample outputs dry only.
